// File: rtl/fpu_issue_pkg.sv
// rtl/fpu_issue_pkg.sv - FP opcodes, queue entry type and size defaults for the FPU issue queue
package fpu_issue_pkg;

  localparam int FPU_DEFAULT_DEPTH    = 4;
  localparam int FPU_DEFAULT_ID_WIDTH = 4;
  localparam int FPU_ID_MAX_W         = 16;

  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_MADD     = 7'h43;
  localparam logic [6:0] OPC_MSUB     = 7'h47;
  localparam logic [6:0] OPC_NMSUB    = 7'h4B;
  localparam logic [6:0] OPC_NMADD    = 7'h4F;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;

  // id is held at the widest supported width; narrower IDs are zero-extended
  typedef struct packed {
    logic [31:0]             instr;
    logic [FPU_ID_MAX_W-1:0] id;
    logic [31:0]             rs0;
    logic                    committed;
    logic                    killed;
  } fpu_entry_t;

endpackage

// File: rtl/fpu_opcode_decode.sv
// rtl/fpu_opcode_decode.sv - combinational RISC-V major-opcode check for F-extension instructions
import fpu_issue_pkg::*;

module fpu_opcode_decode (
  input  logic [6:0] opcode,
  output logic       is_fp
);

  assign is_fp = opcode inside {OPC_LOAD_FP, OPC_STORE_FP, OPC_MADD, OPC_MSUB,
                                OPC_NMSUB, OPC_NMADD, OPC_OP_FP};

endmodule

// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - in-order FP issue queue with commit gating; kill support under FPU_ISSUE_KILL_EN
import fpu_issue_pkg::*;

module fpu_issue_queue #(
  parameter int DEPTH      = FPU_DEFAULT_DEPTH,
  parameter int X_ID_WIDTH = FPU_DEFAULT_ID_WIDTH
) (
  input  logic                         ck,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [31:0]                  issue_instr,
  input  logic [X_ID_WIDTH-1:0]        issue_id,
  input  logic [31:0]                  issue_rs0,
  output logic                         issue_accept,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  input  logic                         fpu_ready,
  output logic                         fpu_enable,
  output logic [31:0]                  fpu_instruction,
  output logic [X_ID_WIDTH-1:0]        fpu_id,
  output logic [31:0]                  fpu_data_fromXreg,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fpu_entry_t              q [DEPTH];
  logic [PW-1:0]           head, tail;
  logic [CW-1:0]           count;
  logic [PW-1:0]           rel [DEPTH];
  logic [DEPTH-1:0]        slot_valid;
  logic [FPU_ID_MAX_W-1:0] cid, iid;
  logic                    is_fp, push, pop, dispatch, kill_req;

  fpu_opcode_decode u_decode (
    .opcode (issue_instr[6:0]),
    .is_fp  (is_fp)
  );

`ifdef FPU_ISSUE_KILL_EN
  assign kill_req = commit_kill;
`else
  logic unused_commit_kill;
  assign unused_commit_kill = commit_kill;
  assign kill_req           = 1'b0;
`endif

  assign cid          = FPU_ID_MAX_W'(commit_id);
  assign iid          = FPU_ID_MAX_W'(issue_id);
  assign issue_accept = is_fp;
  assign issue_ready  = (count != CW'(DEPTH));
  assign occupancy    = count;
  assign push         = issue_valid && issue_ready && is_fp;
  // killed heads drain regardless of fpu_ready; live heads wait for it
  assign pop          = (count != '0) && q[head].committed && (q[head].killed || fpu_ready);
  assign dispatch     = pop && !q[head].killed;

  // a slot is live when its distance from head is below the fill count
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]        = PW'(i) - head;
      slot_valid[i] = (CW'(rel[i]) < count);
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      fpu_enable        <= 1'b0;
      fpu_instruction   <= '0;
      fpu_id            <= '0;
      fpu_data_fromXreg <= '0;
    end else begin
      fpu_enable <= dispatch;
      if (dispatch) begin
        fpu_instruction   <= q[head].instr;
        fpu_id            <= q[head].id[X_ID_WIDTH-1:0];
        fpu_data_fromXreg <= q[head].rs0;
      end
      if (commit_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (slot_valid[i] && q[i].id == cid) begin
            q[i].committed <= 1'b1;
            if (kill_req) q[i].killed <= 1'b1;
          end
        end
      end
      // the tail slot is never live while a push is possible, so this write cannot collide
      if (push) begin
        q[tail] <= '{instr:     issue_instr,
                     id:        iid,
                     rs0:       issue_rs0,
                     committed: commit_valid && (cid == iid),
                     killed:    commit_valid && kill_req && (cid == iid)};
        tail    <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - self-checking bench for fpu_issue_queue against a queue-based reference model
module tb_fpu_issue_queue;

  localparam int DEPTH = 4;
`ifdef FPU_ISSUE_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  id;
    logic [31:0] rs0;
    bit          committed;
    bit          killed;
  } tb_entry_t;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_instr = '0;
  logic [3:0]  issue_id = '0;
  logic [31:0] issue_rs0 = '0;
  logic        issue_accept;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        fpu_ready = 1'b0;
  logic        fpu_enable;
  logic [31:0] fpu_instruction;
  logic [3:0]  fpu_id;
  logic [31:0] fpu_data_fromXreg;
  logic [2:0]  occupancy;

  fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4)) dut (
    .ck                (ck),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_instr       (issue_instr),
    .issue_id          (issue_id),
    .issue_rs0         (issue_rs0),
    .issue_accept      (issue_accept),
    .commit_valid      (commit_valid),
    .commit_id         (commit_id),
    .commit_kill       (commit_kill),
    .fpu_ready         (fpu_ready),
    .fpu_enable        (fpu_enable),
    .fpu_instruction   (fpu_instruction),
    .fpu_id            (fpu_id),
    .fpu_data_fromXreg (fpu_data_fromXreg),
    .occupancy         (occupancy)
  );

  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;

  tb_entry_t   m_q[$];
  bit          model_known = 1'b0;
  bit          exp_en = 1'b0;
  logic [31:0] exp_instr = '0;
  logic [3:0]  exp_id = '0;
  logic [31:0] exp_rs0 = '0;
  logic [3:0]  disp_log[$];
  int          disp_cyc[$];
  int          cyc = 0;
  logic [6:0]  fp_ops [7] = '{7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_fp(input logic [31:0] ins);
    for (int k = 0; k < 7; k++) if (ins[6:0] == fp_ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [3:0] id,
                       input bit cv, input logic [3:0] cid, input bit kl, input bit fr);
    issue_valid  = iv;
    issue_instr  = ins;
    issue_id     = id;
    issue_rs0    = $urandom;
    commit_valid = cv;
    commit_id    = cid;
    commit_kill  = kl;
    fpu_ready    = fr;
  endtask

  // one clock: check combinational outputs, advance the model, clock, check registered outputs
  task automatic cycle();
    tb_entry_t e;
    bit m_ready;
    #1;
    m_ready = (m_q.size() != DEPTH);
    check_eq("issue_accept", 64'(issue_accept), 64'(ref_is_fp(issue_instr)));
    if (model_known) check_eq("issue_ready", 64'(issue_ready), 64'(m_ready));
    if (reset) begin
      m_q.delete();
      exp_en = 0; exp_instr = '0; exp_id = '0; exp_rs0 = '0;
      model_known = 1'b1;
    end else begin
      exp_en = 0;
      if (m_q.size() > 0 && m_q[0].committed && (m_q[0].killed || fpu_ready)) begin
        if (!m_q[0].killed) begin
          exp_en = 1; exp_instr = m_q[0].instr; exp_id = m_q[0].id; exp_rs0 = m_q[0].rs0;
        end
        m_q.delete(0);
      end
      if (commit_valid)
        foreach (m_q[k]) if (m_q[k].id == commit_id) begin
          m_q[k].committed = 1;
          if (KILL_EN && commit_kill) m_q[k].killed = 1;
        end
      if (issue_valid && m_ready && ref_is_fp(issue_instr)) begin
        e.instr = issue_instr; e.id = issue_id; e.rs0 = issue_rs0;
        e.committed = commit_valid && (commit_id == issue_id);
        e.killed    = e.committed && KILL_EN && commit_kill;
        m_q.push_back(e);
      end
    end
    @(posedge ck);
    #1;
    cyc++;
    if (fpu_enable === 1'b1) begin
      disp_log.push_back(fpu_id);
      disp_cyc.push_back(cyc);
    end
    check_eq("fpu_enable", 64'(fpu_enable), 64'(exp_en));
    check_eq("occupancy", 64'(occupancy), 64'(m_q.size()));
    check_eq("fpu_instruction", 64'(fpu_instruction), 64'(exp_instr));
    check_eq("fpu_id", 64'(fpu_id), 64'(exp_id));
    check_eq("fpu_data_fromXreg", 64'(fpu_data_fromXreg), 64'(exp_rs0));
  endtask

  task automatic idle(input int n, input bit fr);
    for (int k = 0; k < n; k++) begin
      drive(0, 32'h0, 4'd0, 0, 4'd0, 0, fr);
      cycle();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 32'h0, 4'd0, 0, 4'd0, 0, 0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ins;
    do_reset();
    do_reset();
    check_eq("reset_occupancy", 64'(occupancy), 64'd0);
    check_eq("reset_ready", 64'(issue_ready), 64'd1);

    // FADD.S id 3, commit, dispatch two edges after the commit
    drive(1, 32'h00208053, 4'd3, 0, 4'd0, 0, 1);
    #1 check_eq("fadd_accept", 64'(issue_accept), 64'd1);
    cycle();
    drive(0, 32'h0, 4'd0, 1, 4'd3, 0, 1);
    cycle();
    check_eq("fadd_no_early_en", 64'(fpu_enable), 64'd0);
    drive(0, 32'h0, 4'd0, 0, 4'd0, 0, 1);
    cycle();
    check_eq("fadd_en", 64'(fpu_enable), 64'd1);
    check_eq("fadd_id", 64'(fpu_id), 64'd3);
    check_eq("fadd_instr", 64'(fpu_instruction), 64'h00208053);

    // non-FP instruction consumed without storage
    drive(1, 32'h00000033, 4'd2, 0, 4'd0, 0, 1);
    #1 check_eq("add_accept", 64'(issue_accept), 64'd0);
    cycle();
    idle(2, 1);
    check_eq("add_occupancy", 64'(occupancy), 64'd0);

    // fill to DEPTH, then drain one
    for (int k = 1; k <= 4; k++) begin
      drive(1, 32'h00308053 | (k << 7), 4'(k), 0, 4'd0, 0, 1);
      cycle();
    end
    check_eq("full_ready", 64'(issue_ready), 64'd0);
    check_eq("full_occupancy", 64'(occupancy), 64'd4);
    drive(0, 32'h0, 4'd0, 1, 4'd1, 0, 1);
    cycle();
    check_eq("full_still_blocked", 64'(issue_ready), 64'd0);
    idle(1, 1);
    check_eq("pop_ready", 64'(issue_ready), 64'd1);
    check_eq("pop_id", 64'(fpu_id), 64'd1);
    do_reset();

    // out-of-order commit, in-order dispatch
    disp_log.delete(); disp_cyc.delete();
    drive(1, 32'h00108053, 4'd5, 0, 4'd0, 0, 1); cycle();
    drive(1, 32'h00110053, 4'd6, 0, 4'd0, 0, 1); cycle();
    drive(0, 32'h0, 4'd0, 1, 4'd6, 0, 1); cycle();
    drive(0, 32'h0, 4'd0, 1, 4'd5, 0, 1); cycle();
    idle(4, 1);
    check_eq("order_count", 64'(disp_log.size()), 64'd2);
    if (disp_log.size() == 2) begin
      check_eq("order_first", 64'(disp_log[0]), 64'd5);
      check_eq("order_second", 64'(disp_log[1]), 64'd6);
      check_eq("order_consecutive", 64'(disp_cyc[1] - disp_cyc[0]), 64'd1);
    end

`ifdef FPU_ISSUE_KILL_EN
    disp_log.delete(); disp_cyc.delete();
    drive(1, 32'h00108053, 4'd7, 0, 4'd0, 0, 1); cycle();
    drive(1, 32'h00110053, 4'd8, 0, 4'd0, 0, 1); cycle();
    drive(0, 32'h0, 4'd0, 1, 4'd7, 1, 1); cycle();
    drive(0, 32'h0, 4'd0, 1, 4'd8, 0, 1); cycle();
    idle(4, 1);
    check_eq("kill_count", 64'(disp_log.size()), 64'd1);
    if (disp_log.size() == 1) check_eq("kill_survivor", 64'(disp_log[0]), 64'd8);
`endif

    // reset mid-operation drops queued work
    for (int k = 9; k <= 11; k++) begin
      drive(1, 32'h00008053, 4'(k), 0, 4'd0, 0, 0);
      cycle();
    end
    do_reset();
    check_eq("midreset_occupancy", 64'(occupancy), 64'd0);
    check_eq("midreset_en", 64'(fpu_enable), 64'd0);
    check_eq("midreset_ready", 64'(issue_ready), 64'd1);
    disp_log.delete(); disp_cyc.delete();
    for (int k = 9; k <= 11; k++) begin
      drive(0, 32'h0, 4'd0, 1, 4'(k), 0, 1);
      cycle();
    end
    idle(3, 1);
    check_eq("midreset_no_dispatch", 64'(disp_log.size()), 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 1) ins[6:0] = fp_ops[$urandom_range(6, 0)];
      drive($urandom_range(1, 0) == 1, ins, 4'($urandom_range(7, 0)),
            $urandom_range(2, 0) != 0, 4'($urandom_range(7, 0)),
            $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0);
      reset = ($urandom_range(63, 0) == 0);
      cycle();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
